// File: rtl/bcd_banner_loader.sv
// Turns UART bytes into banner frames and shift-register commands.
// Frames look like '#' followed by N ASCII digits and CR; L/R/S/P outside a frame become strobes.
module bcd_banner_loader #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [W*N-1:0] data_out,
  output logic           write,
  output logic           set_left,
  output logic           set_right,
  output logic           start,
  output logic           pause,
  output logic           busy,
  output logic           err
);

  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [7:0] ChHash  = 8'h23;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChLeft  = 8'h4C;
  localparam logic [7:0] ChRight = 8'h52;
  localparam logic [7:0] ChStart = 8'h53;
  localparam logic [7:0] ChPause = 8'h50;

  typedef enum logic [1:0] {StIdle, StCollect, StWaitCr} state_e;

  state_e          state;
  logic [W*N-1:0]  staging;
  logic [CntW-1:0] count;
  logic            is_digit;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      staging   <= '0;
      count     <= '0;
      data_out  <= '0;
      write     <= 1'b0;
      set_left  <= 1'b0;
      set_right <= 1'b0;
      start     <= 1'b0;
      pause     <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      write     <= 1'b0;
      set_left  <= 1'b0;
      set_right <= 1'b0;
      start     <= 1'b0;
      pause     <= 1'b0;
      err       <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          StIdle: begin
            case (rx_data)
              ChHash: begin
                staging <= '0;
                count   <= '0;
                state   <= StCollect;
              end
              ChLeft:  set_left  <= 1'b1;
              ChRight: set_right <= 1'b1;
              ChStart: start     <= 1'b1;
              ChPause: pause     <= 1'b1;
              default: ;
            endcase
          end
          StCollect: begin
            if (rx_data == ChHash) begin
              staging <= '0;
              count   <= '0;
            end else if (is_digit) begin
              // Low nibble of an ASCII digit is its BCD value.
              staging <= (staging << W) | (W*N)'(rx_data[3:0]);
              count   <= count + CntW'(1);
              if (count == CntW'(N - 1)) state <= StWaitCr;
            end else begin
              err     <= 1'b1;
              staging <= '0;
              count   <= '0;
              state   <= StIdle;
            end
          end
          StWaitCr: begin
            if (rx_data == ChCr) begin
              data_out <= staging;
              write    <= 1'b1;
              staging  <= '0;
              count    <= '0;
              state    <= StIdle;
            end else if (rx_data == ChHash) begin
              staging <= '0;
              count   <= '0;
              state   <= StCollect;
            end else begin
              err     <= 1'b1;
              staging <= '0;
              count   <= '0;
              state   <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_banner_loader.sv
// Bench for bcd_banner_loader: directed frames plus random byte streams against a frame-level model.
module tb_bcd_banner_loader;

  localparam int W  = 4;
  localparam int N  = 6;
  localparam int DW = W * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [DW-1:0] data_out;
  logic          write, set_left, set_right, start, pause, busy, err;

  bcd_banner_loader #(.W(W), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .data_out (data_out),
    .write    (write),
    .set_left (set_left),
    .set_right(set_right),
    .start    (start),
    .pause    (pause),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: a flag for "inside a frame" and a list of collected digit values.
  bit            m_in_frame;
  int            m_digits[$];
  logic [DW-1:0] m_data;
  logic [5:0]    m_strobe;  // {write, set_left, set_right, start, pause, err}

  task automatic model_reset();
    m_in_frame = 0;
    m_digits.delete();
    m_data   = '0;
    m_strobe = '0;
  endtask

  task automatic model_byte(input bit v, input logic [7:0] b);
    logic [63:0] value;
    m_strobe = '0;
    if (!v) return;
    if (!m_in_frame) begin
      case (b)
        8'h23: begin m_in_frame = 1; m_digits.delete(); end
        8'h4C: m_strobe = 6'b010000;
        8'h52: m_strobe = 6'b001000;
        8'h53: m_strobe = 6'b000100;
        8'h50: m_strobe = 6'b000010;
        default: ;
      endcase
    end else if (b == 8'h23) begin
      m_digits.delete();
    end else if (b >= 8'h30 && b <= 8'h39 && m_digits.size() < N) begin
      m_digits.push_back(int'(b) - 48);
    end else if (b == 8'h0D && m_digits.size() == N) begin
      value = 0;
      foreach (m_digits[i]) value = value * (64'd1 << W) + 64'(m_digits[i]);
      m_data     = value[DW-1:0];
      m_strobe   = 6'b100000;
      m_in_frame = 0;
      m_digits.delete();
    end else begin
      m_strobe   = 6'b000001;
      m_in_frame = 0;
      m_digits.delete();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    model_byte(v, b);
    @(posedge clk);
    #1;
    check("data_out", 64'(data_out), 64'(m_data));
    check("strobes", 64'({write, set_left, set_right, start, pause, err}), 64'(m_strobe));
    check("busy", 64'(busy), 64'(m_in_frame));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", 64'({data_out, write, set_left, set_right, start, pause, busy, err}),
          64'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic send_random_frame();
    step(1'b1, 8'h23);
    for (int i = 0; i < N; i++) step(1'b1, 8'(8'h30 + $urandom_range(0, 9)));
    step(1'b1, 8'h0D);
  endtask

  logic [7:0] cmds [4] = '{8'h4C, 8'h52, 8'h53, 8'h50};

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    do_reset();
    step(1'b0, 8'h00);

    // Good frame
    send_str("#123456");
    step(1'b1, 8'h0D);
    check("frame_value", 64'(data_out), 64'h123456);
    step(1'b0, 8'h00);

    // Back-to-back commands
    send_str("LSPRX");
    check("cmd_keeps_data", 64'(data_out), 64'h123456);

    // Short frame aborts
    send_str("#12");
    step(1'b1, 8'h0D);
    step(1'b0, 8'h00);
    check("abort_keeps_data", 64'(data_out), 64'h123456);

    // Restart mid-frame
    send_str("#98#000007");
    step(1'b1, 8'h0D);
    check("restart_value", 64'(data_out), 64'h000007);

    // Too many digits, then a command
    send_str("#1234567S");

    // Reset mid-frame discards it
    send_str("#12");
    do_reset();
    step(1'b1, 8'h0D);
    step(1'b0, 8'h00);
    check("reset_frame_dropped", 64'(data_out), 64'h0);

    // Random streams
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       step(1'b0, 8'h00);
      else if (r < 16) step(1'b1, 8'h23);
      else if (r < 52) step(1'b1, 8'(8'h30 + $urandom_range(0, 9)));
      else if (r < 62) step(1'b1, 8'h0D);
      else if (r < 74) step(1'b1, cmds[$urandom_range(0, 3)]);
      else if (r < 82) step(1'b1, 8'($urandom));
      else if (r < 98) send_random_frame();
      else if (r < 99) do_reset();
      else             send_str("#1234567");
    end
    step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
